find_max_b: RTL and testbench
=============================

FIND_MAX_B -- requirements
Module: find_max_b

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sample width (unsigned).
REQ-002 Parameter ADDR_WIDTH, default 6, sample index width; max frame length 2^ADDR_WIDTH.
REQ-003 clk_in  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 s_axis_tvalid  input  1  input sample valid.
REQ-006 s_axis_tlast  input  1  marks last sample of frame.
REQ-007 s_axis_tdata  input  DATA_WIDTH  sample magnitude, unsigned.
REQ-008 s_axis_tready  output  1  block accepts samples.
REQ-009 m_axis_tready  input  1  downstream accepts result.
REQ-010 m_axis_tvalid  output  1  result valid.
REQ-011 m_axis_tdata_0  output  DATA_WIDTH  sample immediately before the maximum.
REQ-012 m_axis_tdata_1  output  DATA_WIDTH  maximum sample of frame.
REQ-013 m_axis_tdata_2  output  DATA_WIDTH  sample immediately after the maximum.
REQ-014 m_axis_taddr  output  ADDR_WIDTH  frame index of the maximum (first sample = 0).

Function
REQ-015 Beat accepted when s_axis_tvalid && s_axis_tready on a clock edge; non-accepted cycles change no state.
REQ-016 Two states: COLLECT (s_axis_tready=1, m_axis_tvalid=0) and HOLD (s_axis_tready=0, m_axis_tvalid=1).
REQ-017 COLLECT: per-frame index counter starts at 0, increments per accepted beat, wraps modulo 2^ADDR_WIDTH.
REQ-018 First accepted beat of a frame unconditionally loads max=data, addr=0, prev=0, next=0.
REQ-019 Later beats: unsigned strict compare data > max; on true load max=data, addr=index, prev=previous accepted sample, next=0, set next-pending flag.
REQ-020 Ties keep earliest index (strict compare).
REQ-021 Beat not a new max while next-pending set: next=data, clear flag; further beats leave next unchanged.
REQ-022 Max on first beat -> tdata_0=0; max on last beat -> tdata_2=0.
REQ-023 Accepted beat with s_axis_tlast=1 is processed as in REQ-018..021, then state -> HOLD; results on outputs in HOLD, i.e. m_axis_tvalid rises the cycle after the tlast beat (latency 1 clock).
REQ-024 HOLD: outputs stable; on m_axis_tready=1 edge, state -> COLLECT, m_axis_tvalid=0 next cycle, index and frame-start flag cleared; outputs may retain last values.
REQ-025 Single-beat frame (tvalid+tlast together first beat) -> tdata_0=0, tdata_1=data, tdata_2=0, taddr=0.
REQ-026 Frames longer than 2^ADDR_WIDTH: index wraps, comparison continues; taddr reports wrapped index.
REQ-027 Input samples offered during HOLD are not accepted (tready=0); upstream must hold them.

Reset
REQ-028 rst=1 asynchronously forces: state COLLECT, index 0, flags cleared, m_axis_tvalid=0, m_axis_tdata_0/1/2=0, m_axis_taddr=0; s_axis_tready=0 while rst asserted, 1 the first cycle after release.
REQ-029 Reset mid-frame or during HOLD discards partial/pending result; next frame processed independently.

Verification
REQ-030 Frame 44,45,46,47,47,45,46,45,45,44 (tlast on 10th), m_axis_tready=1 -> m_axis_tvalid one cycle after tlast beat, tdata_0=46, tdata_1=47, tdata_2=47, taddr=3, valid for one cycle.
REQ-031 Frame 90,10,20 -> tdata_0=0, tdata_1=90, tdata_2=10, taddr=0; frame 1,2,3 -> 2,3,0, taddr=2.
REQ-032 Single-beat frame 5 with tlast -> 0,5,0, taddr=0; all-zero 4-beat frame -> 0,0,0, taddr=0.
REQ-033 m_axis_tready=0 for 5 cycles after result -> outputs stable, s_axis_tready=0, offered beats ignored; raise tready -> tvalid low next cycle, s_axis_tready=1, next frame correct.
REQ-034 rst asserted mid-frame after 3 beats -> all outputs 0 immediately; subsequent frame 7,9,8 -> 7,9,8, taddr=1.
REQ-035 Gapped input (tvalid deasserted between beats) of frame 3,8,2 -> same result as ungapped: 3,8,2, taddr=1.

Source files
------------

// File: rtl/find_max_b.sv
// Streams one frame of unsigned samples and reports the maximum with its index
// and its two neighbours, held until the downstream consumer accepts it.
module find_max_b #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk_in,
    input  logic                  rst,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    output logic                  s_axis_tready,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_0,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_1,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_2,
    output logic [ADDR_WIDTH-1:0] m_axis_taddr
);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] idx_reg, idx_next;
    logic                  started_reg, started_next;
    logic                  pending_reg, pending_next;
    logic [DATA_WIDTH-1:0] last_reg, last_next;
    logic [DATA_WIDTH-1:0] max_reg, max_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] prev_reg, prev_next;
    logic [DATA_WIDTH-1:0] nxt_reg, nxt_next;
    logic                  accept;
    logic                  publish;

    assign s_axis_tready = (state_reg == COLLECT) && !rst;
    assign m_axis_tvalid = (state_reg == HOLD);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign publish       = accept && s_axis_tlast;

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        started_next = started_reg;
        pending_next = pending_reg;
        last_next    = last_reg;
        max_next     = max_reg;
        addr_next    = addr_reg;
        prev_next    = prev_reg;
        nxt_next     = nxt_reg;
        case (state_reg)
            COLLECT: begin
                if (accept) begin
                    // The first beat arms the pending flag so its successor
                    // becomes the "after" neighbour of a first-beat maximum.
                    if (!started_reg) begin
                        max_next     = s_axis_tdata;
                        addr_next    = '0;
                        prev_next    = '0;
                        nxt_next     = '0;
                        pending_next = 1'b1;
                        started_next = 1'b1;
                    end else if (s_axis_tdata > max_reg) begin
                        max_next     = s_axis_tdata;
                        addr_next    = idx_reg;
                        prev_next    = last_reg;
                        nxt_next     = '0;
                        pending_next = 1'b1;
                    end else if (pending_reg) begin
                        nxt_next     = s_axis_tdata;
                        pending_next = 1'b0;
                    end
                    last_next = s_axis_tdata;
                    idx_next  = idx_reg + 1'b1;
                    if (s_axis_tlast) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (m_axis_tready) begin
                    state_next   = COLLECT;
                    idx_next     = '0;
                    started_next = 1'b0;
                    pending_next = 1'b0;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_reg   <= COLLECT;
            idx_reg     <= '0;
            started_reg <= 1'b0;
            pending_reg <= 1'b0;
            last_reg    <= '0;
            max_reg     <= '0;
            addr_reg    <= '0;
            prev_reg    <= '0;
            nxt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            started_reg <= started_next;
            pending_reg <= pending_next;
            last_reg    <= last_next;
            max_reg     <= max_next;
            addr_reg    <= addr_next;
            prev_reg    <= prev_next;
            nxt_reg     <= nxt_next;
        end
    end

    // Result registers change only when a frame closes, so HOLD outputs are stable.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            m_axis_tdata_0 <= '0;
            m_axis_tdata_1 <= '0;
            m_axis_tdata_2 <= '0;
            m_axis_taddr   <= '0;
        end else if (publish) begin
            m_axis_tdata_0 <= prev_next;
            m_axis_tdata_1 <= max_next;
            m_axis_tdata_2 <= nxt_next;
            m_axis_taddr   <= addr_next;
        end
    end

endmodule

// File: tb/tb_find_max_b.sv
// Directed bench for find_max_b: a frame-level model (max/neighbours over the
// whole frame) checked every cycle, plus literal expectations per scenario.
module tb_find_max_b;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk_in = 1'b0;
    logic          rst = 1'b1;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tready;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tvalid;
    logic [DW-1:0] m_axis_tdata_0;
    logic [DW-1:0] m_axis_tdata_1;
    logic [DW-1:0] m_axis_tdata_2;
    logic [AW-1:0] m_axis_taddr;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] smp[$];
    logic [DW-1:0] exp_d0 = '0, exp_d1 = '0, exp_d2 = '0;
    logic [AW-1:0] exp_addr = '0;

    find_max_b #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tready  (s_axis_tready),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tdata_0 (m_axis_tdata_0),
        .m_axis_tdata_1 (m_axis_tdata_1),
        .m_axis_tdata_2 (m_axis_tdata_2),
        .m_axis_taddr   (m_axis_taddr)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Frame-level model: earliest strict maximum, neighbours by position.
    task automatic model_frame();
        int mi = 0;
        int n  = smp.size();
        for (int i = 1; i < n; i++)
            if (smp[i] > smp[mi]) mi = i;
        exp_d1   = smp[mi];
        exp_d0   = (mi > 0) ? smp[mi-1] : '0;
        exp_d2   = (mi < n - 1) ? smp[mi+1] : '0;
        exp_addr = AW'(mi % (1 << AW));
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int guard = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        while (!s_axis_tready && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", 0, 1);
        @(posedge clk_in);
        #1;
    endtask

    // Sends smp as one frame; checks latency, literal result and drop-on-accept.
    task automatic run_frame(input int gap, input bit use_lit,
                             input int l0, input int l1, input int l2, input int la);
        model_frame();
        for (int i = 0; i < smp.size(); i++) begin
            send_beat(smp[i], (i == smp.size() - 1));
            if (gap > 0 && i != smp.size() - 1) begin
                s_axis_tvalid = 1'b0;
                repeat (gap) @(posedge clk_in);
                #1;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        @(negedge clk_in);
        chk("latency_tvalid", m_axis_tvalid, 1);
        if (use_lit) begin
            chk("lit_tdata_0", m_axis_tdata_0, l0);
            chk("lit_tdata_1", m_axis_tdata_1, l1);
            chk("lit_tdata_2", m_axis_tdata_2, l2);
            chk("lit_taddr", m_axis_taddr, la);
        end
        $display("frame len=%0d -> %0d,%0d,%0d addr=%0d", smp.size(),
                 m_axis_tdata_0, m_axis_tdata_1, m_axis_tdata_2, m_axis_taddr);
        if (m_axis_tready) begin
            @(negedge clk_in);
            chk("tvalid_one_cycle", m_axis_tvalid, 0);
            chk("ready_after_ack", s_axis_tready, 1);
        end
    endtask

    // Compare process: whenever a result is presented it must match the model.
    always @(negedge clk_in) begin
        if (!rst) begin
            chk("tready_vs_tvalid", s_axis_tready, !m_axis_tvalid);
            if (m_axis_tvalid) begin
                chk("model_tdata_0", m_axis_tdata_0, exp_d0);
                chk("model_tdata_1", m_axis_tdata_1, exp_d1);
                chk("model_tdata_2", m_axis_tdata_2, exp_d2);
                chk("model_taddr", m_axis_taddr, exp_addr);
            end
        end
    end

    initial begin
        #1;
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata_1", m_axis_tdata_1, 0);
        chk("rst_taddr", m_axis_taddr, 0);
        #20;
        rst = 1'b0;
        @(negedge clk_in);
        chk("ready_after_rst", s_axis_tready, 1);

        smp = '{44, 45, 46, 47, 47, 45, 46, 45, 45, 44};
        run_frame(0, 1, 46, 47, 47, 3);
        smp = '{90, 10, 20};
        run_frame(0, 1, 0, 90, 10, 0);
        smp = '{1, 2, 3};
        run_frame(0, 1, 2, 3, 0, 2);
        smp = '{5};
        run_frame(0, 1, 0, 5, 0, 0);
        smp = '{0, 0, 0, 0};
        run_frame(0, 1, 0, 0, 0, 0);
        smp = '{3, 8, 2};
        run_frame(2, 1, 3, 8, 2, 1);
        smp = '{4, 9, 9, 1};
        run_frame(0, 1, 4, 9, 9, 1);

        // Long frame: index wraps, maximum at position 66 reports index 2.
        smp.delete();
        for (int i = 0; i < 70; i++) smp.push_back(DW'((i * 7) % 100));
        smp[66] = 250;
        run_frame(0, 1, 55, 250, 69, 2);

        // Downstream stall: result held, offered beats ignored.
        m_axis_tready = 1'b0;
        smp = '{11, 22, 33};
        run_frame(0, 1, 22, 33, 0, 2);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 8'd200;
        s_axis_tlast  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_in);
            chk("hold_tvalid", m_axis_tvalid, 1);
            chk("hold_tready", s_axis_tready, 0);
            chk("hold_tdata_1", m_axis_tdata_1, 33);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge clk_in);
        chk("release_tvalid", m_axis_tvalid, 0);
        chk("release_tready", s_axis_tready, 1);
        smp = '{10, 30, 20};
        run_frame(0, 1, 10, 30, 20, 1);

        // Reset mid-frame after three beats.
        send_beat(8'd100, 1'b0);
        send_beat(8'd50, 1'b0);
        send_beat(8'd60, 1'b0);
        s_axis_tvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_tready", s_axis_tready, 0);
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_tdata_0", m_axis_tdata_0, 0);
        chk("midrst_tdata_1", m_axis_tdata_1, 0);
        chk("midrst_tdata_2", m_axis_tdata_2, 0);
        chk("midrst_taddr", m_axis_taddr, 0);
        @(negedge clk_in);
        rst = 1'b0;
        @(negedge clk_in);
        chk("midrst_ready_after", s_axis_tready, 1);
        smp = '{7, 9, 8};
        run_frame(0, 1, 7, 9, 8, 1);

        repeat (3) @(negedge clk_in);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
